regfile_sb: RTL and testbench

//  Parametrised integer register file for the core: 2 async read ports, 2 write ports
//  (primary writeback + secondary/late writeback), optional same-cycle write-to-read

---
 rtl/regfile_sb_if.sv | 47 ++++
 rtl/regfile_sb.sv | 113 +++++++++++
 tb/tb_regfile_sb.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
//------------------------------------------------------------------------------
// Module : regfile_sb_if
// Desc   : Read, write and issue bundle for the scoreboarded register file.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   rd1_addr;
    logic [AW-1:0]   rd2_addr;
    logic [XLEN-1:0] rd1_data;
    logic [XLEN-1:0] rd2_data;
    logic            rd1_busy;
    logic            rd2_busy;
    logic            wr1_en;
    logic [AW-1:0]   wr1_addr;
    logic [XLEN-1:0] wr1_data;
    logic            wr2_en;
    logic [AW-1:0]   wr2_addr;
    logic [XLEN-1:0] wr2_data;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic            busy_any;

    modport master (
        output rd1_addr, rd2_addr,
        output wr1_en, wr1_addr, wr1_data,
        output wr2_en, wr2_addr, wr2_data,
        output iss_en, iss_addr,
        input  rd1_data, rd2_data, rd1_busy, rd2_busy, busy_any
    );

    modport slave (
        input  rd1_addr, rd2_addr,
        input  wr1_en, wr1_addr, wr1_data,
        input  wr2_en, wr2_addr, wr2_data,
        input  iss_en, iss_addr,
        output rd1_data, rd2_data, rd1_busy, rd2_busy, busy_any
    );
endinterface

`default_nettype wire

// File: rtl/regfile_sb.sv
//------------------------------------------------------------------------------
// Module : regfile_sb
// Desc   : 2R/2W integer register file with optional write bypass and busy-bit
//          scoreboard for in-flight producers.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    regfile_sb_if.slave rf
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] w_regs [NREG];
    logic [NREG-1:0] w_busy;

    //--------------------------------------------------------------------------
    // Per-register storage and busy bit
    //--------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NREG; i++) begin : g_reg
            if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
                assign w_regs[i] = '0;
                assign w_busy[i] = 1'b0;
            end else begin : g_store
                logic [XLEN-1:0] r_q;
                logic            r_busy;
                logic            w_hit1;
                logic            w_hit2;
                logic            w_set;

                assign w_hit1 = rf.wr1_en && (rf.wr1_addr == AW'(i));
                assign w_hit2 = rf.wr2_en && (rf.wr2_addr == AW'(i));
                assign w_set  = rf.iss_en && (rf.iss_addr == AW'(i));

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_q    <= '0;
                        r_busy <= 1'b0;
                    end else begin
                        // Late writeback port has priority on an address clash
                        if (w_hit2) begin
                            r_q <= rf.wr2_data;
                        end else if (w_hit1) begin
                            r_q <= rf.wr1_data;
                        end
                        // A fresh issue outranks a retiring producer
                        if (w_set) begin
                            r_busy <= 1'b1;
                        end else if (w_hit1 || w_hit2) begin
                            r_busy <= 1'b0;
                        end
                    end
                end

                assign w_regs[i] = r_q;
                assign w_busy[i] = r_busy;
            end
        end
    endgenerate

    //--------------------------------------------------------------------------
    // Read ports
    //--------------------------------------------------------------------------
    function automatic logic [XLEN-1:0] f_read(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] stored,
        input logic            we1,
        input logic [AW-1:0]   wa1,
        input logic [XLEN-1:0] wd1,
        input logic            we2,
        input logic [AW-1:0]   wa2,
        input logic [XLEN-1:0] wd2
    );
        logic [XLEN-1:0] v;
        v = stored;
        if (BYPASS != 0) begin
            if (we1 && (wa1 == addr)) v = wd1;
            if (we2 && (wa2 == addr)) v = wd2;
        end
        // Hard-wired zero must also mask forwarded data
        if ((ZERO_REG != 0) && (addr == '0)) v = '0;
        return v;
    endfunction

    logic [XLEN-1:0] w_rd1_data;
    logic [XLEN-1:0] w_rd2_data;

    always_comb begin
        w_rd1_data = f_read(rf.rd1_addr, w_regs[rf.rd1_addr],
                            rf.wr1_en, rf.wr1_addr, rf.wr1_data,
                            rf.wr2_en, rf.wr2_addr, rf.wr2_data);
        w_rd2_data = f_read(rf.rd2_addr, w_regs[rf.rd2_addr],
                            rf.wr1_en, rf.wr1_addr, rf.wr1_data,
                            rf.wr2_en, rf.wr2_addr, rf.wr2_data);
    end

    assign rf.rd1_data = w_rd1_data;
    assign rf.rd2_data = w_rd2_data;
    assign rf.rd1_busy = w_busy[rf.rd1_addr];
    assign rf.rd2_busy = w_busy[rf.rd2_addr];
    assign rf.busy_any = |w_busy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
//------------------------------------------------------------------------------
// Module : tb_regfile_sb
// Desc   : Bench for regfile_sb; a bypass/zero-reg build and a 64-bit no-bypass
//          build run side by side against an array-based reference.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_sb;
    localparam int AX  = 32;
    localparam int AN  = 32;
    localparam int AAW = 5;
    localparam int BX  = 64;
    localparam int BN  = 16;
    localparam int BAW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(AX), .NREG(AN)) ifa ();
    regfile_sb_if #(.XLEN(BX), .NREG(BN)) ifb ();

    regfile_sb #(.XLEN(AX), .NREG(AN), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rf(ifa.slave));
    regfile_sb #(.XLEN(BX), .NREG(BN), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rf(ifb.slave));

    int total = 0;
    int bad   = 0;
    bit m_valid = 1'b0;

    logic [AX-1:0] ma_regs [AN];
    bit            ma_busy [AN];
    logic [BX-1:0] mb_regs [BN];
    bit            mb_busy [BN];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural view of build A: r0 is zero, same-cycle writes forward, port 2 wins
    function automatic logic [AX-1:0] exp_a_rd(input int addr);
        if (addr == 0) return '0;
        if (ifa.wr2_en && int'(ifa.wr2_addr) == addr) return ifa.wr2_data;
        if (ifa.wr1_en && int'(ifa.wr1_addr) == addr) return ifa.wr1_data;
        return ma_regs[addr];
    endfunction

    function automatic bit exp_a_busy(input int addr);
        return (addr == 0) ? 1'b0 : ma_busy[addr];
    endfunction

    // Compare every cycle, then advance the reference by one clock
    always @(negedge clk) begin
        bit any_a;
        bit any_b;
        any_a = 1'b0;
        any_b = 1'b0;
        for (int i = 1; i < AN; i++) any_a |= ma_busy[i];
        for (int i = 0; i < BN; i++) any_b |= mb_busy[i];
        if (m_valid) begin
            chk("a_rd1",   64'(ifa.rd1_data), 64'(exp_a_rd(int'(ifa.rd1_addr))));
            chk("a_rd2",   64'(ifa.rd2_data), 64'(exp_a_rd(int'(ifa.rd2_addr))));
            chk("a_busy1", 64'(ifa.rd1_busy), 64'(exp_a_busy(int'(ifa.rd1_addr))));
            chk("a_busy2", 64'(ifa.rd2_busy), 64'(exp_a_busy(int'(ifa.rd2_addr))));
            chk("a_any",   64'(ifa.busy_any), 64'(any_a));
            chk("b_rd1",   ifb.rd1_data, mb_regs[ifb.rd1_addr]);
            chk("b_rd2",   ifb.rd2_data, mb_regs[ifb.rd2_addr]);
            chk("b_busy1", 64'(ifb.rd1_busy), 64'(mb_busy[ifb.rd1_addr]));
            chk("b_busy2", 64'(ifb.rd2_busy), 64'(mb_busy[ifb.rd2_addr]));
            chk("b_any",   64'(ifb.busy_any), 64'(any_b));
        end
        if (!rst_n) begin
            for (int i = 0; i < AN; i++) begin ma_regs[i] = '0; ma_busy[i] = 1'b0; end
            for (int i = 0; i < BN; i++) begin mb_regs[i] = '0; mb_busy[i] = 1'b0; end
            m_valid = 1'b1;
        end else begin
            if (ifa.wr1_en) begin ma_regs[ifa.wr1_addr] = ifa.wr1_data; ma_busy[ifa.wr1_addr] = 1'b0; end
            if (ifa.wr2_en) begin ma_regs[ifa.wr2_addr] = ifa.wr2_data; ma_busy[ifa.wr2_addr] = 1'b0; end
            if (ifa.iss_en) ma_busy[ifa.iss_addr] = 1'b1;
            ma_regs[0] = '0;
            ma_busy[0] = 1'b0;
            if (ifb.wr1_en) begin mb_regs[ifb.wr1_addr] = ifb.wr1_data; mb_busy[ifb.wr1_addr] = 1'b0; end
            if (ifb.wr2_en) begin mb_regs[ifb.wr2_addr] = ifb.wr2_data; mb_busy[ifb.wr2_addr] = 1'b0; end
            if (ifb.iss_en) mb_busy[ifb.iss_addr] = 1'b1;
        end
    end

    task automatic idle();
        ifa.wr1_en = 1'b0; ifa.wr2_en = 1'b0; ifa.iss_en = 1'b0;
        ifb.wr1_en = 1'b0; ifb.wr2_en = 1'b0; ifb.iss_en = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic at_check();
        @(negedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        ifa.rd1_addr = AAW'($urandom_range(0, AN - 1));
        ifa.rd2_addr = AAW'($urandom_range(0, AN - 1));
        ifa.wr1_en   = 1'($urandom_range(0, 1));
        ifa.wr1_addr = AAW'($urandom_range(0, AN - 1));
        ifa.wr1_data = $urandom;
        ifa.wr2_en   = 1'($urandom_range(0, 1));
        ifa.wr2_addr = AAW'($urandom_range(0, AN - 1));
        ifa.wr2_data = $urandom;
        ifa.iss_en   = 1'($urandom_range(0, 1));
        ifa.iss_addr = AAW'($urandom_range(0, AN - 1));
        ifb.rd1_addr = BAW'($urandom_range(0, BN - 1));
        ifb.rd2_addr = BAW'($urandom_range(0, BN - 1));
        ifb.wr1_en   = 1'($urandom_range(0, 1));
        ifb.wr1_addr = BAW'($urandom_range(0, BN - 1));
        ifb.wr1_data = {$urandom, $urandom};
        ifb.wr2_en   = 1'($urandom_range(0, 1));
        ifb.wr2_addr = BAW'($urandom_range(0, BN - 1));
        ifb.wr2_data = {$urandom, $urandom};
        ifb.iss_en   = 1'($urandom_range(0, 1));
        ifb.iss_addr = BAW'($urandom_range(0, BN - 1));
    endtask

    initial begin
        idle();
        ifa.rd1_addr = '0; ifa.rd2_addr = '0; ifa.wr1_addr = '0; ifa.wr2_addr = '0;
        ifa.wr1_data = '0; ifa.wr2_data = '0; ifa.iss_addr = '0;
        ifb.rd1_addr = '0; ifb.rd2_addr = '0; ifb.wr1_addr = '0; ifb.wr2_addr = '0;
        ifb.wr1_data = '0; ifb.wr2_data = '0; ifb.iss_addr = '0;
        rst_n = 1'b0;
        repeat (2) nxt();
        rst_n = 1'b1;
        ifa.rd1_addr = AAW'(1);
        at_check();
        chk("rst_a_any", 64'(ifa.busy_any), 64'd0);
        chk("rst_a_rd1", 64'(ifa.rd1_data), 64'd0);
        chk("rst_b_any", 64'(ifb.busy_any), 64'd0);

        // Fill, then reset with a write/issue in the reset cycle
        for (int i = 0; i < AN; i++) begin
            nxt();
            ifa.wr1_en = 1'b1; ifa.wr1_addr = AAW'(i); ifa.wr1_data = 32'hA5A5_0000 + 32'(i);
        end
        nxt();
        idle();
        ifa.rd1_addr = AAW'(7);
        at_check();
        chk("fill_r7", 64'(ifa.rd1_data), 64'hA5A5_0007);
        nxt();
        rst_n = 1'b0;
        ifa.wr1_en = 1'b1; ifa.wr1_addr = AAW'(3); ifa.wr1_data = 32'h1234_5678;
        ifa.iss_en = 1'b1; ifa.iss_addr = AAW'(4);
        nxt();
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < AN; i++) begin
            ifa.rd1_addr = AAW'(i);
            ifa.rd2_addr = AAW'(i);
            at_check();
            chk("post_rst_rd", 64'(ifa.rd1_data), 64'd0);
            nxt();
        end
        at_check();
        chk("post_rst_any", 64'(ifa.busy_any), 64'd0);
        nxt();

        // Dual write collision and distinct addresses
        ifa.wr1_en = 1'b1; ifa.wr1_addr = AAW'(5); ifa.wr1_data = 32'h1111;
        ifa.wr2_en = 1'b1; ifa.wr2_addr = AAW'(5); ifa.wr2_data = 32'h2222;
        nxt();
        idle();
        ifa.rd1_addr = AAW'(5);
        at_check();
        chk("collide_r5", 64'(ifa.rd1_data), 64'h2222);
        nxt();
        ifa.wr1_en = 1'b1; ifa.wr1_addr = AAW'(6); ifa.wr1_data = 32'h6666;
        ifa.wr2_en = 1'b1; ifa.wr2_addr = AAW'(7); ifa.wr2_data = 32'h7777;
        nxt();
        idle();
        ifa.rd1_addr = AAW'(6); ifa.rd2_addr = AAW'(7);
        at_check();
        chk("dual_r6", 64'(ifa.rd1_data), 64'h6666);
        chk("dual_r7", 64'(ifa.rd2_data), 64'h7777);
        nxt();

        // Bypass on A, none on B
        ifa.wr1_en = 1'b1; ifa.wr1_addr = AAW'(9); ifa.wr1_data = 32'hDEAD_BEEF;
        ifa.rd2_addr = AAW'(9);
        ifb.wr1_en = 1'b1; ifb.wr1_addr = BAW'(9); ifb.wr1_data = 64'hCAFE_F00D_0000_0009;
        ifb.rd1_addr = BAW'(9);
        at_check();
        chk("a_bypass", 64'(ifa.rd2_data), 64'hDEAD_BEEF);
        chk("b_nobyp_old", ifb.rd1_data, 64'd0);
        nxt();
        idle();
        at_check();
        chk("b_nobyp_new", ifb.rd1_data, 64'hCAFE_F00D_0000_0009);
        nxt();

        // Register zero
        ifa.wr1_en = 1'b1; ifa.wr1_addr = '0; ifa.wr1_data = 32'hFFFF_FFFF;
        ifa.wr2_en = 1'b1; ifa.wr2_addr = '0; ifa.wr2_data = 32'hFFFF_FFFF;
        ifa.iss_en = 1'b1; ifa.iss_addr = '0;
        ifa.rd1_addr = '0;
        ifb.wr1_en = 1'b1; ifb.wr1_addr = '0; ifb.wr1_data = 64'hFFFF_FFFF;
        ifb.rd1_addr = '0;
        at_check();
        chk("zero_byp", 64'(ifa.rd1_data), 64'd0);
        nxt();
        idle();
        at_check();
        chk("zero_rd",   64'(ifa.rd1_data), 64'd0);
        chk("zero_busy", 64'(ifa.rd1_busy), 64'd0);
        chk("zero_any",  64'(ifa.busy_any), 64'd0);
        chk("b_r0",      ifb.rd1_data, 64'hFFFF_FFFF);
        nxt();

        // Scoreboard set / clear / set-beats-clear
        ifa.iss_en = 1'b1; ifa.iss_addr = AAW'(12); ifa.rd1_addr = AAW'(12);
        nxt();
        idle();
        at_check();
        chk("sb_set",     64'(ifa.rd1_busy), 64'd1);
        chk("sb_set_any", 64'(ifa.busy_any), 64'd1);
        nxt();
        ifa.wr2_en = 1'b1; ifa.wr2_addr = AAW'(12); ifa.wr2_data = 32'h0C0C;
        nxt();
        idle();
        at_check();
        chk("sb_clr",     64'(ifa.rd1_busy), 64'd0);
        chk("sb_clr_any", 64'(ifa.busy_any), 64'd0);
        nxt();
        ifa.iss_en = 1'b1; ifa.iss_addr = AAW'(12);
        nxt();
        ifa.wr1_en = 1'b1; ifa.wr1_addr = AAW'(12); ifa.wr1_data = 32'h0D0D;
        nxt();
        idle();
        at_check();
        chk("sb_set_wins", 64'(ifa.rd1_busy), 64'd1);
        nxt();

        // Wide build, top address
        ifb.wr1_en = 1'b1; ifb.wr1_addr = BAW'(15); ifb.wr1_data = 64'h0123_4567_89AB_CDEF;
        ifb.rd2_addr = BAW'(15);
        nxt();
        idle();
        at_check();
        chk("b_r15", ifb.rd2_data, 64'h0123_4567_89AB_CDEF);
        nxt();

        // Random traffic with reset injected mid-run
        for (int c = 0; c < 10000; c++) begin
            randomize_inputs();
            rst_n = (c == 5000 || $urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            nxt();
        end
        rst_n = 1'b1;
        idle();
        repeat (2) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
